// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and selects the next fetch address.
// Handles sequential fetch, branch, J-type jump and jump-register redirects,
// post-redirect squash bubbles, stall, halt/resume and a sticky JR
// misalignment error state.
//
// Optional feature: define PC_SEQ_PERF_EN to add fetch_count/bubble_count.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   stall             hold PC and state this cycle
//   halt / resume     enter / leave HALTED
//   branch_taken      conditional branch taken, target pc+4+(branch_offset<<2)
//   jump              J-type jump, target {pc+4[31:28], jump_target, 2'b00}
//   jump_reg          jump-register, target reg_target (must be word aligned)
//   out_pc            current fetch address
//   valid_fetch       instruction at out_pc is to be executed (combinational)
//   state             0=RUN 1=BUBBLE 2=HALTED 3=ERROR
//   misaligned        sticky JR misalignment flag
//   fetch_count       (PC_SEQ_PERF_EN) unstalled RUN fetch edges
//   bubble_count      (PC_SEQ_PERF_EN) unstalled BUBBLE edges
module pc_sequencer #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned BRANCH_PENALTY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        halt,
    input  logic        resume,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic [31:0] out_pc,
    output logic        valid_fetch,
    output logic [1:0]  state,
    output logic        misaligned
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_BUBBLE = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;
    localparam logic [1:0] PENALTY   = 2'(BRANCH_PENALTY);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [1:0]  r_cnt;
    logic        r_mis;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [1:0]  w_cnt_nxt;
    logic        w_mis_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic        w_redir;
    logic [31:0] w_redir_tgt;

    // Candidate targets, all modulo 2^32
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_tgt   = w_pc_plus4 + (branch_offset << 2);
    assign w_j_tgt    = {w_pc_plus4[31:28], jump_target, 2'b00};

    // Aligned redirect selection, JR > J > branch
    always_comb begin
        w_redir     = 1'b0;
        w_redir_tgt = w_pc_plus4;
        if (jump_reg) begin
            w_redir     = (reg_target[1:0] == 2'b00);
            w_redir_tgt = reg_target;
        end else if (jump) begin
            w_redir     = 1'b1;
            w_redir_tgt = w_j_tgt;
        end else if (branch_taken) begin
            w_redir     = 1'b1;
            w_redir_tgt = w_br_tgt;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_cnt   <= 2'd0;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mis   <= w_mis_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_mis_nxt   = r_mis;
        case (r_state)
            ST_RUN: begin
                if (halt) begin
                    w_state_nxt = ST_HALTED;
                end else if (stall) begin
                    w_state_nxt = ST_RUN;
                end else if (jump_reg && !w_redir) begin
                    // Misaligned JR traps; PC stays on the JR
                    w_state_nxt = ST_ERROR;
                    w_mis_nxt   = 1'b1;
                end else if (w_redir) begin
                    w_pc_nxt    = w_redir_tgt;
                    w_cnt_nxt   = PENALTY;
                    w_state_nxt = (PENALTY != 2'd0) ? ST_BUBBLE : ST_RUN;
                end else begin
                    w_pc_nxt = w_pc_plus4;
                end
            end
            ST_BUBBLE: begin
                if (halt) begin
                    w_state_nxt = ST_HALTED;
                    w_cnt_nxt   = 2'd0;
                end else if (!stall) begin
                    w_cnt_nxt = r_cnt - 2'd1;
                    if (r_cnt <= 2'd1) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = 2'd0;
                    end
                end
            end
            ST_HALTED: begin
                if (resume && !halt) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                // ERROR is left only through reset
                w_state_nxt = ST_ERROR;
            end
        endcase
    end

    // Outputs
    always_comb begin
        valid_fetch = (r_state == ST_RUN) && !rst;
    end

    assign out_pc     = r_pc;
    assign state      = r_state;
    assign misaligned = r_mis;

`ifdef PC_SEQ_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    // Performance counters, free-running modulo 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else begin
            if ((r_state == ST_RUN) && !stall && !halt) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if ((r_state == ST_BUBBLE) && !stall) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign fetch_count  = r_fetch_cnt;
    assign bubble_count = r_bubble_cnt;
`endif

endmodule
